// File: rtl/mdu_seq_if.sv
// ---------------------------------------------------------------------------
// mdu_seq_if
// Request/response bundle between the execute stage and the mdu_seq
// multiply/divide unit.
//   i_mdu_rs1/i_mdu_rs2 : operands (dividend/multiplicand, divisor/multiplier)
//   i_mdu_op            : RISC-V M funct3
//   i_mdu_valid         : request valid        (master -> unit)
//   o_mdu_ready         : unit idle, can accept (unit -> master)
//   o_mdu_rd            : result, stable while o_mdu_rd_valid is high
//   o_mdu_rd_valid      : result valid         (unit -> master)
//   i_mdu_rd_ready      : consumer takes result (master -> unit)
// The i_/o_ prefixes are seen from the unit (slave) side.
// ---------------------------------------------------------------------------
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_mdu_rs1;
  logic [WIDTH-1:0] i_mdu_rs2;
  logic [2:0]       i_mdu_op;
  logic             i_mdu_valid;
  logic             o_mdu_ready;
  logic [WIDTH-1:0] o_mdu_rd;
  logic             o_mdu_rd_valid;
  logic             i_mdu_rd_ready;

  modport master (
    output i_mdu_rs1, i_mdu_rs2, i_mdu_op, i_mdu_valid, i_mdu_rd_ready,
    input  o_mdu_ready, o_mdu_rd, o_mdu_rd_valid
  );

  modport slave (
    input  i_mdu_rs1, i_mdu_rs2, i_mdu_op, i_mdu_valid, i_mdu_rd_ready,
    output o_mdu_ready, o_mdu_rd, o_mdu_rd_valid
  );
endinterface

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// RISC-V M-extension multiply/divide unit, one operation in flight.
//   Multiply : operands widened to WIDTH+1 bits, product pushed through a
//              MUL_STAGES-deep register pipeline; result MUL_STAGES+1 edges
//              after accept.
//   Divide   : one setup cycle, WIDTH restoring iterations (1 bit/cycle),
//              one sign fix-up cycle; result WIDTH+2 edges after accept.
//   Div-by-zero and signed overflow return the RISC-V defined values.
// Ports
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset, aborts any operation in flight
//   mdu    : mdu_seq_if.slave request/response handshake bundle
// Build option
//   MDU_DIV_FASTPATH_EN : when defined, divide-by-zero and signed overflow
//                         skip the iteration loop (result 2 edges after
//                         accept). Result values are identical either way.
// ---------------------------------------------------------------------------
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mdu_seq_if.slave mdu
);
  localparam int P_DATA_MSB = WIDTH - 1;
  localparam int CNT_MAX    = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES + 1;
  localparam int CW         = $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [P_DATA_MSB:0] rs1_q, rs1_d;
  logic [P_DATA_MSB:0] rs2_q, rs2_d;
  logic [2:0]          op_q, op_d;
  logic [P_DATA_MSB:0] rd_q, rd_d;
  logic [P_DATA_MSB:0] dvd_q, dvd_d;   // dividend magnitude, becomes quotient
  logic [P_DATA_MSB:0] rem_q, rem_d;   // partial remainder
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                div_init_q, div_init_d;
  logic                div_fix_q, div_fix_d;

  // ---------------------------------------------------------------- multiply
  // MUL/MULH: both signed, MULHSU: rs1 signed only, MULHU: both unsigned.
  logic                        a_signed, b_signed;
  logic signed [WIDTH:0]       mul_a, mul_b;
  logic signed [2*WIDTH-1:0]   mul_a_x, mul_b_x;
  logic [2*WIDTH-1:0]          mul_p;
  logic [2*WIDTH-1:0]          mul_last;
  logic [P_DATA_MSB:0]         mul_res;

  assign a_signed = (op_q[1:0] != 2'b11);
  assign b_signed = ~op_q[1];
  assign mul_a    = {a_signed & rs1_q[P_DATA_MSB], rs1_q};
  assign mul_b    = {b_signed & rs2_q[P_DATA_MSB], rs2_q};
  // Only the low 2*WIDTH product bits are needed; they are exact mod 2^(2W).
  assign mul_a_x  = (2*WIDTH)'(mul_a);
  assign mul_b_x  = (2*WIDTH)'(mul_b);
  assign mul_p    = mul_a_x * mul_b_x;

  // Operands are stable from accept, so the pipeline simply free-runs.
  for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_pipe
    logic [2*WIDTH-1:0] stage_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge i_clk) stage_q <= mul_p;
    end else begin : g_tail
      always_ff @(posedge i_clk) stage_q <= g_pipe[gi-1].stage_q;
    end
  end

  assign mul_last = g_pipe[MUL_STAGES-1].stage_q;
  assign mul_res  = (op_q[1:0] == 2'b00) ? mul_last[P_DATA_MSB:0]
                                         : mul_last[2*WIDTH-1:WIDTH];

  // ------------------------------------------------------------------ divide
  logic                div_signed, s1, s2, div_zero, div_ovf;
  logic [P_DATA_MSB:0] rs1_mag, rs2_mag, quo_fix, rem_fix, div_special, div_res;
  logic [WIDTH:0]      rem_shift, rem_diff;

  assign div_signed = ~op_q[0];
  assign s1         = div_signed & rs1_q[P_DATA_MSB];
  assign s2         = div_signed & rs2_q[P_DATA_MSB];
  assign rs1_mag    = s1 ? (~rs1_q + 1'b1) : rs1_q;
  assign rs2_mag    = s2 ? (~rs2_q + 1'b1) : rs2_q;
  assign div_zero   = (rs2_q == '0);
  assign div_ovf    = div_signed && (rs1_q == {1'b1, {P_DATA_MSB{1'b0}}})
                                 && (rs2_q == '1);

  // Trial subtraction; a set top bit means the divisor did not fit.
  assign rem_shift  = {rem_q, dvd_q[P_DATA_MSB]};
  assign rem_diff   = rem_shift - {1'b0, rs2_mag};

  assign quo_fix    = (s1 ^ s2) ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix    = s1 ? (~rem_q + 1'b1) : rem_q;
  // The loop gives the wrong sign for a negative dividend over zero, so the
  // architected special results are always selected explicitly.
  assign div_special = div_zero ? (op_q[1] ? rs1_q : '1)
                                : (op_q[1] ? '0 : rs1_q);
  assign div_res     = (div_zero || div_ovf) ? div_special
                                             : (op_q[1] ? rem_fix : quo_fix);

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    op_d       = op_q;
    rd_d       = rd_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    div_init_d = div_init_q;
    div_fix_d  = div_fix_q;

    unique case (state_q)
      S_IDLE: begin
        if (mdu.i_mdu_valid) begin
          rs1_d      = mdu.i_mdu_rs1;
          rs2_d      = mdu.i_mdu_rs2;
          op_d       = mdu.i_mdu_op;
          cnt_d      = '0;
          div_init_d = 1'b1;
          div_fix_d  = 1'b0;
          state_d    = mdu.i_mdu_op[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MUL_STAGES)) begin
          rd_d    = mul_res;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (div_init_q) begin
          div_init_d = 1'b0;
          dvd_d      = rs1_mag;
          rem_d      = '0;
          cnt_d      = CW'(P_DATA_MSB);
`ifdef MDU_DIV_FASTPATH_EN
          if (div_zero || div_ovf) begin
            div_fix_d = 1'b1;
          end
`endif
        end else if (div_fix_q) begin
          div_fix_d = 1'b0;
          rd_d      = div_res;
          state_d   = S_DONE;
        end else begin
          if (!rem_diff[WIDTH]) begin
            rem_d = rem_diff[P_DATA_MSB:0];
            dvd_d = {dvd_q[P_DATA_MSB-1:0], 1'b1};
          end else begin
            rem_d = rem_shift[P_DATA_MSB:0];
            dvd_d = {dvd_q[P_DATA_MSB-1:0], 1'b0};
          end
          if (cnt_q == '0) begin
            div_fix_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        if (mdu.i_mdu_rd_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      div_init_q <= 1'b0;
      div_fix_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      div_init_q <= div_init_d;
      div_fix_q  <= div_fix_d;
    end
  end

  assign mdu.o_mdu_ready    = (state_q == S_IDLE);
  assign mdu.o_mdu_rd_valid = (state_q == S_DONE);
  assign mdu.o_mdu_rd       = rd_q;

endmodule

// File: tb/tb_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq
// Directed and random operations on mdu_seq (WIDTH=32, MUL_STAGES=2),
// checked against an arithmetic reference model of the M extension, with
// latency, back-pressure and mid-operation reset checks.
// ---------------------------------------------------------------------------
module tb_mdu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mdu   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit integers.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic special;
    if (!op[2]) return 3;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MDU_DIV_FASTPATH_EN
    if (special) return 2;
`else
    if (special) return 34;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // One transaction: accept, wait for the result, optional back-pressure,
  // then confirm the return to idle with the result held.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp_cycles);
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    exp     = ref_op(op, a, b);
    exp_lat = ref_lat(op, a, b);
    @(negedge clk);
    check("idle_ready", bus.o_mdu_ready, 1);
    bus.i_mdu_valid    = 1'b1;
    bus.i_mdu_op       = op;
    bus.i_mdu_rs1      = a;
    bus.i_mdu_rs2      = b;
    bus.i_mdu_rd_ready = (bp_cycles == 0);
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    bus.i_mdu_op    = 3'($urandom);
    bus.i_mdu_rs1   = $urandom;
    bus.i_mdu_rs2   = $urandom;
    lat = 0;
    while (!bus.o_mdu_rd_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", bus.o_mdu_rd, exp);
    $display("op=%0d rs1=%h rs2=%h rd=%h exp=%h lat=%0d", op, a, b, bus.o_mdu_rd, exp, lat);
    for (int i = 0; i < bp_cycles; i++) begin
      bus.i_mdu_valid = 1'b1;
      bus.i_mdu_op    = 3'($urandom);
      bus.i_mdu_rs1   = $urandom;
      @(posedge clk); #1;
      check("bp_valid", bus.o_mdu_rd_valid, 1);
      check("bp_rd", bus.o_mdu_rd, exp);
      check("bp_ready", bus.o_mdu_ready, 0);
    end
    bus.i_mdu_valid    = 1'b0;
    bus.i_mdu_rd_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", bus.o_mdu_rd_valid, 0);
    check("post_ready", bus.o_mdu_ready, 1);
    check("post_rd_hold", bus.o_mdu_rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.i_mdu_valid    = 1'b0;
    bus.i_mdu_op       = 3'd0;
    bus.i_mdu_rs1      = '0;
    bus.i_mdu_rs2      = '0;
    bus.i_mdu_rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.o_mdu_ready, 1);
    check("rst_valid", bus.o_mdu_rd_valid, 0);
    check("rst_rd", bus.o_mdu_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply examples
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // Divide examples
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    // Divide-by-zero and signed overflow
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // Back-pressure for 10 cycles in DONE, on both paths
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_op(3'd6, 32'hFFFF_F000, 32'd37, 10);

    // Reset in the middle of a divide
    @(negedge clk);
    bus.i_mdu_valid = 1'b1;
    bus.i_mdu_op    = 3'd4;
    bus.i_mdu_rs1   = 32'hFFFF_FC18;
    bus.i_mdu_rs2   = 32'd7;
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("div_busy_ready", bus.o_mdu_ready, 0);
    check("div_busy_valid", bus.o_mdu_rd_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", bus.o_mdu_ready, 1);
    check("midrst_valid", bus.o_mdu_rd_valid, 0);
    check("midrst_rd", bus.o_mdu_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
